// File: rtl/circuito_jogo_param_pkg.sv
// jogo_pkg: FSM state codes shown on db_estado and a helper for counter/address widths
package jogo_pkg;
  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    ESPERA_JOGADA = 4'd2,
    COMPARA       = 4'd4,
    PROX_JOGADA   = 4'd5,
    ESPERA_NOVA   = 4'd6,
    ESCREVE       = 4'd7,
    PROX_RODADA   = 4'd8,
    FIM_GANHOU    = 4'd10,
    FIM_TIMEOUT   = 4'd13,
    FIM_PERDEU    = 4'd14
  } estado_t;
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/circuito_jogo_param_if.sv
// circuito_jogo_param_if: game I/O bundle (jogar, modo_timeout, botoes in; leds, pronto/ganhou/perdeu and db_* out)
interface circuito_jogo_param_if #(
  parameter int N_BOTOES = 4,
  parameter int AW = 5
);
  logic                jogar;
  logic                modo_timeout;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                pronto;
  logic                ganhou;
  logic                perdeu;
  logic                db_timeout;
  logic                db_igual;
  logic [3:0]          db_estado;
  logic [AW-1:0]       db_rodada;
  logic [AW-1:0]       db_contagem;
  logic                db_jogada;
  modport master (
    output jogar, modo_timeout, botoes,
    input  leds, pronto, ganhou, perdeu, db_timeout, db_igual, db_estado, db_rodada, db_contagem, db_jogada
  );
  modport slave (
    input  jogar, modo_timeout, botoes,
    output leds, pronto, ganhou, perdeu, db_timeout, db_igual, db_estado, db_rodada, db_contagem, db_jogada
  );
endinterface

// File: rtl/circuito_jogo_param_memoria.sv
// memoria_jogadas: play storage (clock, we, addr_w, dado_w sync write; addr_r -> dado_r async read)
module memoria_jogadas #(
  parameter int N_BOTOES = 4,
  parameter int MAX_RODADAS = 16,
  parameter int MW = 4
) (
  input  logic                clock,
  input  logic                we,
  input  logic [MW-1:0]       addr_w,
  input  logic [MW-1:0]       addr_r,
  input  logic [N_BOTOES-1:0] dado_w,
  output logic [N_BOTOES-1:0] dado_r
);
  logic [N_BOTOES-1:0] mem [MAX_RODADAS];
  always_ff @(posedge clock) if (we) mem[addr_w] <= dado_w;
  assign dado_r = mem[addr_r];
endmodule

// File: rtl/circuito_jogo_param.sv
// circuito_jogo_param: memory game top (clock, active-low sync reset, io slave: buttons/jogar/modo_timeout in, leds/status/debug out)
module circuito_jogo_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES = 4,
  parameter int MAX_RODADAS = 16,
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int AW = largura(MAX_RODADAS + 1)
) (
  input logic clock,
  input logic reset,
  circuito_jogo_param_if.slave io
);
  localparam int MW = largura(MAX_RODADAS);
  localparam int TW = largura(TIMEOUT_CICLOS);
  estado_t             estado, prox;
  logic [AW-1:0]       rodada, contagem;
  logic [TW-1:0]       timer;
  logic [N_BOTOES-1:0] reg_jogada, mem_q;
  logic                botoes_q, jogada, espera, estouro, igual, ultima;
  logic                pronto, ganhou, perdeu, db_timeout;
  assign jogada  = (|io.botoes) & ~botoes_q;
  assign espera  = estado == ESPERA_JOGADA || estado == ESPERA_NOVA;
  assign estouro = io.modo_timeout && timer == TW'(TIMEOUT_CICLOS - 1) && !jogada;
  assign igual   = reg_jogada == mem_q;
  assign ultima  = contagem + 1'b1 == rodada;
  memoria_jogadas #(.N_BOTOES(N_BOTOES), .MAX_RODADAS(MAX_RODADAS), .MW(MW)) u_mem (
    .clock (clock),
    .we    (estado == ESCREVE),
    .addr_w(rodada[MW-1:0]),
    .addr_r(contagem[MW-1:0]),
    .dado_w(reg_jogada),
    .dado_r(mem_q)
  );
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:       prox = io.jogar ? PREPARA : INICIAL;
      PREPARA:       prox = ESPERA_NOVA;
      ESPERA_JOGADA: prox = jogada ? COMPARA : estouro ? FIM_TIMEOUT : ESPERA_JOGADA;
      COMPARA:       prox = !igual ? FIM_PERDEU : !ultima ? PROX_JOGADA :
                            rodada == AW'(MAX_RODADAS) ? FIM_GANHOU : ESPERA_NOVA;
      PROX_JOGADA:   prox = ESPERA_JOGADA;
      ESPERA_NOVA:   prox = jogada ? ESCREVE : estouro ? FIM_TIMEOUT : ESPERA_NOVA;
      ESCREVE:       prox = PROX_RODADA;
      PROX_RODADA:   prox = ESPERA_JOGADA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: prox = io.jogar ? PREPARA : estado;
      default:       prox = INICIAL;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado     <= INICIAL;
      rodada     <= '0;
      contagem   <= '0;
      timer      <= '0;
      reg_jogada <= '0;
      botoes_q   <= 1'b0;
      pronto     <= 1'b0;
      ganhou     <= 1'b0;
      perdeu     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      estado     <= prox;
      botoes_q   <= |io.botoes;
      pronto     <= prox inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
      ganhou     <= prox == FIM_GANHOU;
      perdeu     <= prox == FIM_PERDEU || prox == FIM_TIMEOUT;
      db_timeout <= prox == FIM_TIMEOUT;
      // timer is zero on entry to a wait state and saturates at the last count
      timer      <= !espera ? '0 : timer == TW'(TIMEOUT_CICLOS - 1) ? timer : timer + 1'b1;
      if (estado == PREPARA) begin
        rodada     <= '0;
        contagem   <= '0;
        reg_jogada <= '0;
      end
      if (espera && jogada) reg_jogada <= io.botoes;
      if (estado == PROX_JOGADA) contagem <= contagem + 1'b1;
      if (estado == PROX_RODADA) begin
        rodada   <= rodada + 1'b1;
        contagem <= '0;
      end
    end
  end
  assign io.leds        = reg_jogada;
  assign io.pronto      = pronto;
  assign io.ganhou      = ganhou;
  assign io.perdeu      = perdeu;
  assign io.db_timeout  = db_timeout;
  // only positions already written this game are meaningful
  assign io.db_igual    = contagem < rodada && igual;
  assign io.db_estado   = estado;
  assign io.db_rodada   = rodada;
  assign io.db_contagem = contagem;
  assign io.db_jogada   = jogada;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// tb_circuito_jogo_param: randomized and directed game sessions checked against a sequence-level reference model
module tb_circuito_jogo_param;
  import jogo_pkg::*;
  localparam int NB = 4;
  localparam int MAXR = 3;
  localparam int TO = 50;
  localparam int AW = largura(MAXR + 1);
  logic clock = 1'b0;
  logic reset = 1'b0;
  circuito_jogo_param_if #(.N_BOTOES(NB), .AW(AW)) io();
  circuito_jogo_param #(.N_BOTOES(NB), .MAX_RODADAS(MAXR), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock),
    .reset(reset),
    .io   (io)
  );
  always #5 clock = ~clock;
  int total = 0;
  int bad = 0;
  int ciclo = 0;
  int t_ent = 0;
  logic [3:0] est_ant = 4'd0;
  logic [3:0] seq[$];
  int mrod = 0;
  int mcont = 0;
  bit novo = 1'b1;
  int exp_est = 0;
  always @(posedge clock) ciclo <= ciclo + 1;
  always @(negedge clock) begin
    if (io.db_estado == 4'd2 && est_ant != 4'd2) t_ent = ciclo;
    est_ant = io.db_estado;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic iniciar();
    #1 io.jogar = 1'b1;
    @(posedge clock);
    #1 io.jogar = 1'b0;
    chk("prepara", 32'(io.db_estado), 1);
    seq.delete();
    mrod = 0;
    mcont = 0;
    novo = 1'b1;
    exp_est = 6;
    @(posedge clock);
    @(negedge clock);
    chk("ini_estado", 32'(io.db_estado), 6);
    chk("ini_rodada", 32'(io.db_rodada), 0);
    chk("ini_contagem", 32'(io.db_contagem), 0);
    chk("ini_leds", 32'(io.leds), 0);
    chk("ini_pronto", 32'(io.pronto), 0);
  endtask
  task automatic press(input logic [3:0] v, input int gap, input int h);
    logic [3:0] esperado;
    int extra;
    bit era_novo;
    repeat (gap) @(posedge clock);
    #1 io.botoes = v;
    #1 chk("pulso", 32'(io.db_jogada), 1);
    era_novo = novo;
    esperado = novo ? 4'd0 : seq[mcont];
    if (novo) begin
      seq.push_back(v);
      mrod++;
      mcont = 0;
      novo = 1'b0;
      exp_est = 2;
    end else if (v != esperado) exp_est = 14;
    else if (mcont == mrod - 1) begin
      if (mrod == MAXR) exp_est = 10;
      else begin
        novo = 1'b1;
        exp_est = 6;
      end
    end else begin
      mcont++;
      exp_est = 2;
    end
    @(posedge clock);
    @(negedge clock);
    chk("captura", 32'(io.db_estado), era_novo ? 7 : 4);
    if (!era_novo) chk("igual", 32'(io.db_igual), 32'(v == esperado));
    extra = 32'(io.db_jogada);
    for (int i = 1; i < h; i++) begin
      @(negedge clock);
      extra += 32'(io.db_jogada);
    end
    @(posedge clock);
    #1 io.botoes = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("pulso_unico", extra, 0);
    chk("estado", 32'(io.db_estado), exp_est);
    chk("rodada", 32'(io.db_rodada), mrod);
    chk("contagem", 32'(io.db_contagem), mcont);
    chk("leds", 32'(io.leds), 32'(v));
    chk("pronto", 32'(io.pronto), 32'(exp_est >= 10));
    chk("ganhou", 32'(io.ganhou), 32'(exp_est == 10));
    chk("perdeu", 32'(io.perdeu), 32'(exp_est == 14));
    chk("db_timeout", 32'(io.db_timeout), 0);
  endtask
  task automatic play_random();
    logic [3:0] v;
    int k;
    iniciar();
    k = 0;
    while (exp_est != 10 && exp_est != 14 && k < 20) begin
      v = novo ? 4'($urandom_range(1, 15)) : seq[mcont];
      if (!novo && $urandom_range(0, 9) == 0) begin
        logic [3:0] w;
        do w = 4'($urandom_range(1, 15)); while (w == v);
        v = w;
      end
      press(v, $urandom_range(0, 6), $urandom_range(1, 3));
      k++;
    end
    chk("jogo_termina", 32'(io.pronto), 1);
  endtask
  initial begin
    int n;
    int fora;
    int gap;
    io.jogar = 1'b0;
    io.modo_timeout = 1'b1;
    io.botoes = '0;
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_estado", 32'(io.db_estado), 0);
    chk("rst_pronto", 32'(io.pronto), 0);
    chk("rst_ganhou", 32'(io.ganhou), 0);
    chk("rst_perdeu", 32'(io.perdeu), 0);
    chk("rst_leds", 32'(io.leds), 0);
    chk("rst_rodada", 32'(io.db_rodada), 0);
    chk("rst_contagem", 32'(io.db_contagem), 0);
    chk("rst_timeout", 32'(io.db_timeout), 0);
    chk("rst_igual", 32'(io.db_igual), 0);
    // full win, one press held for 10 cycles
    iniciar();
    press(4'b0001, 0, 1);
    press(4'b0001, 2, 10);
    press(4'b0010, 0, 2);
    press(4'b0001, 1, 1);
    press(4'b0010, 0, 3);
    press(4'b0100, 3, 1);
    press(4'b0001, 0, 1);
    press(4'b0010, 0, 2);
    press(4'b0100, 0, 1);
    chk("win_ganhou", 32'(io.ganhou), 1);
    chk("win_rodada", 32'(io.db_rodada), 3);
    // wrong second play in round 2
    iniciar();
    press(4'b0001, 0, 1);
    press(4'b0001, 0, 1);
    press(4'b0010, 0, 1);
    press(4'b0001, 0, 1);
    press(4'b1000, 0, 1);
    chk("erro_estado", 32'(io.db_estado), 14);
    chk("erro_contagem", 32'(io.db_contagem), 1);
    chk("erro_timeout", 32'(io.db_timeout), 0);
    // restart from FIM_PERDEU, then time out in round 2
    iniciar();
    press(4'b0001, 0, 1);
    press(4'b0001, 0, 1);
    press(4'b0010, 0, 1);
    n = 0;
    while (io.db_estado != 4'd13 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_atraso", ciclo - t_ent, TO);
    chk("timeout_perdeu", 32'(io.perdeu), 1);
    chk("timeout_flag", 32'(io.db_timeout), 1);
    chk("timeout_pronto", 32'(io.pronto), 1);
    chk("timeout_ganhou", 32'(io.ganhou), 0);
    // press on the last allowed cycle wins over the timeout
    iniciar();
    press(4'b0100, 0, 1);
    gap = t_ent + TO - 1 - ciclo;
    chk("limite_gap_ok", 32'(gap >= 0), 1);
    press(4'b0100, gap < 0 ? 0 : gap, 1);
    press(4'b1001, 0, 1);
    // timeout disabled: wait indefinitely, then re-enable
    io.modo_timeout = 1'b0;
    fora = 0;
    repeat (500) begin
      @(negedge clock);
      if (io.db_estado != 4'd2) fora++;
    end
    chk("sem_timeout", fora, 0);
    io.modo_timeout = 1'b1;
    @(negedge clock);
    chk("religa_timeout", 32'(io.db_estado), 13);
    // reset in the middle of round 2
    iniciar();
    press(4'b0001, 0, 1);
    press(4'b0001, 0, 1);
    press(4'b0010, 0, 1);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_meio_estado", 32'(io.db_estado), 0);
    chk("rst_meio_rodada", 32'(io.db_rodada), 0);
    chk("rst_meio_contagem", 32'(io.db_contagem), 0);
    chk("rst_meio_leds", 32'(io.leds), 0);
    chk("rst_meio_perdeu", 32'(io.perdeu), 0);
    repeat (12) play_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circuito_jogo_param.md
Name: circuito_jogo_param

Overview: Parametrised next-generation memory-game circuit. The player builds the sequence: each round repeats all stored plays, then enters one new play that is appended to internal memory. Button count, sequence depth and timeout are generic, and timeout can be switched on or off at run time. Top-level game block; the FPGA wrapper adds 7-segment decoding of the db_* outputs.

Parameters:
N_BOTOES, 4, number of buttons/LEDs (width of one play)
MAX_RODADAS, 16, memory depth; the game is won after MAX_RODADAS plays are stored and then repeated correctly
TIMEOUT_CICLOS, 3000, clock cycles allowed per wait state before timeout
AW, $clog2(MAX_RODADAS+1), derived width of the round and contagem counters

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
jogar  in  1  start/restart request, level
modo_timeout  in  1  1 = timeout enabled, 0 = wait indefinitely
botoes  in  N_BOTOES  raw buttons (already debounced externally)
leds  out  N_BOTOES  last registered play
pronto  out  1  game finished
ganhou  out  1  win
perdeu  out  1  loss (wrong play or timeout)
db_timeout  out  1  loss was caused by timeout
db_igual  out  1  registered play == mem[contagem]
db_estado  out  4  current FSM state code
db_rodada  out  AW  current round
db_contagem  out  AW  position within the round
db_jogada  out  1  one-cycle play pulse

Behaviour:
- Reset (reset==0 at a rising edge): state INICIAL; all outputs and counters 0; memory contents undefined, never read before being written. Reset applies in any state, mid-game included.
- Play pulse: botoes_q <= |botoes each cycle; jogada = (|botoes) & ~botoes_q. One pulse per press; holding a button generates no further pulses.
- States and codes:
  - INICIAL 0: jogar=1 -> PREPARA.
  - PREPARA 1: clear rodada, contagem, leds, timer and flags -> ESPERA_NOVA.
  - ESPERA_JOGADA 2: on jogada, reg_jogada <= botoes -> COMPARA.
  - COMPARA 4: one cycle.
    - Mismatch -> FIM_PERDEU.
    - Match and contagem < rodada-1 -> PROX_JOGADA.
    - Match and contagem == rodada-1: if rodada == MAX_RODADAS -> FIM_GANHOU, else -> ESPERA_NOVA.
  - PROX_JOGADA 5: contagem++ -> ESPERA_JOGADA.
  - ESPERA_NOVA 6: on jogada, reg_jogada <= botoes -> ESCREVE.
  - ESCREVE 7: mem[rodada] <= reg_jogada -> PROX_RODADA.
  - PROX_RODADA 8: rodada++, contagem <= 0 -> ESPERA_JOGADA.
  - FIM_GANHOU 10, FIM_PERDEU 14, FIM_TIMEOUT 13: hold; jogar=1 -> PREPARA.
- leds = reg_jogada.
- Moore outputs:
  - pronto=1 in all FIM states.
  - ganhou=1 in FIM_GANHOU.
  - perdeu=1 in FIM_PERDEU and FIM_TIMEOUT.
  - db_timeout=1 in FIM_TIMEOUT.
- jogar is ignored outside INICIAL and the FIM states.
- Plays are compared as full N_BOTOES vectors. A multi-button press is stored and compared as-is.
- Timer:
  - Cleared on entry to every non-wait state.
  - Increments in ESPERA_JOGADA and ESPERA_NOVA.
  - When timer == TIMEOUT_CICLOS-1, modo_timeout=1 and no jogada in that cycle -> FIM_TIMEOUT.
  - If jogada arrives in the same cycle, the play wins.
  - With modo_timeout=0 the timer saturates and is ignored.
  - Changing modo_timeout mid-wait takes effect on the next cycle.
- Latency: press edge -> jogada 0 cycles (combinational), COMPARA on the next edge, result state one cycle later.
- Round 0 compares nothing; it only stores address 0. Final round: rodada == MAX_RODADAS compares all MAX_RODADAS entries, with no write.

Decomposition:
- Package jogo_pkg: state code localparams; a helper function computing AW.
- Sub-module memoria_jogadas: MAX_RODADAS x N_BOTOES registers, synchronous write, asynchronous read.
- FSM, counters, timer and edge detector stay in circuito_jogo_param.

Test Plan:
- Power-up: reset=0 for 1 cycle -> db_estado=0; pronto, ganhou, perdeu, leds all 0.
- MAX_RODADAS=3, modo_timeout=1. jogar; store 0001; repeat 0001, store 0010; repeat 0001,0010, store 0100; repeat 0001,0010,0100 -> ganhou=1, pronto=1, db_rodada=3.
- Error: sequence 0001,0010 stored; in round 2 press 0001 then 1000 -> FIM_PERDEU (14), perdeu=1, db_timeout=0, db_contagem=1.
- Timeout: TIMEOUT_CICLOS=50; after round 2 starts, no press -> FIM_TIMEOUT exactly 50 cycles after entering ESPERA_JOGADA; perdeu=1, db_timeout=1. Same case with modo_timeout=0 -> stays in state 2 for 500 cycles.
- Boundary: press lands on timer==TIMEOUT_CICLOS-1 -> COMPARA, no timeout. Holding a button 10 cycles -> exactly one db_jogada pulse.
- Reset mid-game in round 2 -> INICIAL next edge, all counters 0. Then jogar from FIM_PERDEU restarts at PREPARA with db_rodada=0.
